// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment display scanner: one-hot digit selects over a shared segment bus,
// with PWM brightness, blink, leading-zero suppression and frame-synchronous data updates.
module seg_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int BLINK_FRAMES   = 62,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  sclk,
  input  logic                  nrst,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  input  logic [3:0]            bright,
  input  logic                  disp_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int PWM_STEP = SCAN_DIV / 16;
  localparam int SW       = $clog2(SCAN_DIV);
  localparam int PW       = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
  localparam int DW       = $clog2(DIGITS);
  localparam int BW       = $clog2(BLINK_FRAMES + 1);

  localparam logic [SW-1:0]     SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]     GUARD_END  = SW'(GUARD);
  localparam logic [PW-1:0]     PWM_LAST   = PW'(PWM_STEP - 1);
  localparam logic [DW-1:0]     DIGIT_LAST = DW'(DIGITS - 1);
  localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [DIGITS-1:0] SEL_OFF    = SEL_ACTIVE_LOW ? '1 : '0;
  localparam logic [7:0]        SEG_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]        CODE_BLANK = 4'd10;

  // Active-high gfedcba pattern for each 4-bit character code.
  function automatic logic [6:0] seg_map(input logic [3:0] code);
    case (code)
      4'd0:    seg_map = 7'h3F;
      4'd1:    seg_map = 7'h06;
      4'd2:    seg_map = 7'h5B;
      4'd3:    seg_map = 7'h4F;
      4'd4:    seg_map = 7'h66;
      4'd5:    seg_map = 7'h6D;
      4'd6:    seg_map = 7'h7D;
      4'd7:    seg_map = 7'h07;
      4'd8:    seg_map = 7'h7F;
      4'd9:    seg_map = 7'h6F;
      4'd10:   seg_map = 7'h00;
      4'd11:   seg_map = 7'h40;
      4'd12:   seg_map = 7'h79;
      4'd13:   seg_map = 7'h50;
      4'd14:   seg_map = 7'h76;
      default: seg_map = 7'h38;
    endcase
  endfunction

  // Scan timing state
  logic [SW-1:0] slot_cnt;
  logic [PW-1:0] pwm_div;
  logic [3:0]    pwm;
  logic [DW-1:0] digit_idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Staging and active display data
  logic                      pending;
  logic [DIGITS-1:0][3:0]    stg_code;
  logic [DIGITS-1:0]         stg_dp;
  logic [DIGITS-1:0]         stg_blink;
  logic [DIGITS-1:0][3:0]    act_code;
  logic [DIGITS-1:0]         act_dp;
  logic [DIGITS-1:0]         act_blink;

  logic              slot_wrap;
  logic              frame_end;
  logic [DIGITS-1:0] lz_blank;
  logic              zero_run;
  logic [6:0]        char_pat;
  logic              sel_on;
  logic [DIGITS-1:0] sel_nxt;
  logic [7:0]        seg_nxt;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign frame_end = slot_wrap && (digit_idx == DIGIT_LAST);

  // NOTE: every sequential block uses non-blocking assignments so all registers
  // sample the same pre-edge values, regardless of block or statement order.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      slot_cnt  <= '0;
      pwm_div   <= '0;
      pwm       <= '0;
      digit_idx <= '0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      pwm_div   <= '0;
      pwm       <= '0;
      digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (pwm_div == PWM_LAST) begin
        pwm_div <= '0;
        pwm     <= pwm + 1'b1;
      end else begin
        pwm_div <= pwm_div + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_end) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // NOTE: the code registers are reset (to blank) because the display must show a
  // defined pattern straight out of reset; plain storage arrays normally would not be.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      pending   <= 1'b0;
      stg_code  <= {DIGITS{CODE_BLANK}};
      stg_dp    <= '0;
      stg_blink <= '0;
      act_code  <= {DIGITS{CODE_BLANK}};
      act_dp    <= '0;
      act_blink <= '0;
    end else begin
      if (load && !frame_end) begin
        stg_code  <= digits;
        stg_dp    <= dp;
        stg_blink <= blink_mask;
        pending   <= 1'b1;
      end
      // A load landing exactly on the boundary bypasses staging.
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          act_code  <= digits;
          act_dp    <= dp;
          act_blink <= blink_mask;
        end else if (pending) begin
          act_code  <= stg_code;
          act_dp    <= stg_dp;
          act_blink <= stg_blink;
        end
      end
    end
  end

  // NOTE: each always_comb assigns defaults to every output first, so no path
  // through the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run    = zero_run & (act_code[k] == 4'd0);
      lz_blank[k] = zero_run;
    end
  end

  always_comb begin
    char_pat = seg_map(act_code[digit_idx]);
    if (lz_en && lz_blank[digit_idx]) begin
      char_pat = 7'h00;
    end
    seg_nxt = {act_dp[digit_idx], char_pat} ^ SEG_OFF;

    sel_on  = disp_en
           && (slot_cnt >= GUARD_END)
           && (pwm <= bright)
           && !(blink_phase && act_blink[digit_idx]);
    sel_nxt = sel_on ? (DIGITS'(1) << digit_idx) : '0;
  end

  // sel and seg share one register stage so they switch on the same edge.
  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      sel        <= SEL_OFF;
      seg        <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      sel        <= sel_nxt ^ SEL_OFF;
      seg        <= seg_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed 7-segment display driver, successor to the fixed 8-digit common-anode scanner. It time-multiplexes DIGITS 4-bit character codes onto one shared segment bus and one-hot digit selects. Over the fixed scanner it adds selectable polarity, per-digit decimal points, per-digit blink, leading-zero suppression, 16-level brightness PWM, anti-ghost guard time and tear-free frame-synchronous updates. It sits between the clock/DS1302 formatting logic and the board's sel/seg pins.

## Interface
- DIGITS, 8, number of digits (2..16); index 0 is rightmost.
- SCAN_DIV, 50000, sclk cycles per digit slot; must be a multiple of 16 and ≥ 32.
- GUARD, 2, cycles at the start of each slot with all selects inactive; must be < SCAN_DIV/16.
- BLINK_FRAMES, 62, frames per blink half-period.
- SEG_ACTIVE_LOW, 1, 1 = segment lines low-active.
- SEL_ACTIVE_LOW, 0, 1 = digit selects low-active.
- sclk  in  1  system clock (50 MHz nominal).
- nrst  in  1  asynchronous, active-low reset.
- digits  in  4*DIGITS  character codes; digit k is bits [4k+3:4k].
- dp  in  DIGITS  decimal point per digit.
- blink_mask  in  DIGITS  1 = digit blinks.
- lz_en  in  1  leading-zero suppression enable.
- bright  in  4  brightness; duty = (bright+1)/16.
- disp_en  in  1  0 = all selects inactive.
- load  in  1  one-cycle strobe; captures digits/dp/blink_mask into staging.
- sel  out  DIGITS  one-hot digit select, bit k drives digit k.
- seg  out  8  {DP,G,F,E,D,C,B,A}.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- slot_cnt counts 0..SCAN_DIV-1 and wraps. On wrap, digit_idx advances 0..DIGITS-1 and wraps.
- A frame boundary is the cycle in which slot_cnt wraps with digit_idx = DIGITS-1.
- pwm is 4-bit and increments every SCAN_DIV/16 cycles. It is 0 at slot start.
- load copies the inputs into staging and sets pending. At the frame boundary, if pending is set, staging is moved to the active register and pending clears.
- If load coincides with the boundary, the active register takes that cycle's inputs directly.
- Code map (active-high gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, 10 blank=00, 11 dash=40, 12 E=79, 13 r=50, 14 H=76, 15 L=38.
- DP bit = active dp[k]. The whole byte is inverted when SEG_ACTIVE_LOW=1.
- Leading-zero suppression (lz_en=1): scanning from index DIGITS-1 downward, code-0 digits render blank until the first non-zero code. Digit 0 is never suppressed. dp is still shown on suppressed digits.
- blink_phase toggles every BLINK_FRAMES frames and is 0 after reset. A digit with blink_mask=1 has its select inactive while blink_phase=1.
- The current digit's select is active only when all of the following hold:
  - disp_en=1;
  - slot_cnt ≥ GUARD;
  - pwm ≤ bright;
  - the digit is not blinked off.
- Otherwise all selects are inactive. seg always shows the current digit's pattern.

## Timing
- All outputs are registered. sel and seg for a given slot change on the same edge, so no segment/select skew is allowed.
- Output latency is 1 cycle from the internal counter state.
- Reset values (during and after nrst low):
  - sel all inactive (0 if SEL_ACTIVE_LOW=0, else all 1s);
  - seg all off (FF if SEG_ACTIVE_LOW=1, else 00);
  - frame_done 0;
  - counters 0, blink_phase 0, pending 0;
  - active and staging codes all 10 (blank), dp 0, blink_mask 0.
- After reset release, digit 0 is scanned first. sel[0] first goes active on the edge GUARD+1 cycles after release (bright=15, disp_en=1).
- frame_done pulses high in the cycle following the frame boundary, concurrent with the new active data taking effect on digit 0.
- Reset asserted mid-frame returns all outputs to reset values immediately (asynchronously) and discards pending.
- Changes on bright, lz_en and disp_en take effect at the next cycle with 1-cycle output latency; they are not frame-synchronised.

## Test plan
- Basic scan (DIGITS=4, SCAN_DIV=32, GUARD=2, bright=15, digits=0x4321, load): after the first frame_done, sel cycles 0001→0010→0100→1000 with 32-cycle slots, each inactive for 2 cycles at slot start. seg = F9, A4, B0, 99 (active-low), aligned with sel.
- Tear-free update: load 0x5678 mid-frame. The remaining slots of that frame still show 0x4321; the new codes appear only after the next frame_done.
- Leading zeros (lz_en=1, digits=0x0070, dp=0100): digits 3 and 0 render blank/0 respectively: seg FF, F8 ("7"), C0, and digit 2 shows 7F (DP only). With code 0x0000, only digit 0 shows C0.
- Brightness: bright=3 gives sel active for cycles 2..7 of each 32-cycle slot (pwm 0..3). bright=0 gives cycles 2..1 = none except pwm 0 window minus guard.
- Blink (BLINK_FRAMES=2, blink_mask=0001): sel[0] is active in frames 0–1, inactive in frames 2–3, and so on. Other digits are unaffected.
- Reset mid-slot: assert nrst low while sel=0100. sel=0000 and seg=FF at once. After release, digits render blank until a load and frame boundary complete.
